// File: rtl/ifm_sparse_chunk_writer.sv
// rtl/ifm_sparse_chunk_writer.sv - dense IFM beat compressor feeding a ping-pong sparse chunk buffer
module ifm_sparse_chunk_writer #(
    parameter int BUS_SIZE = 8,
    parameter int MEM_SIZE = 32,
    localparam int N   = MEM_SIZE / BUS_SIZE,
    localparam int CW  = (N > 1) ? $clog2(N) : 1,
    localparam int NZW = $clog2(MEM_SIZE) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [BUS_SIZE*8-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  in_last_i,
    output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
    output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
    output logic                  wr_valid_o,
    output logic [CW-1:0]         wr_count_o,
    output logic                  wr_sel_o,
    input  logic [1:0]            bank_release_i,
    output logic [1:0]            bank_full_o,
    output logic [2*NZW-1:0]      chunk_nz_cnt_o
);
    localparam int PW = $clog2(BUS_SIZE) + 1;

    typedef enum logic {FILL, PAD} state_t;

    state_t                  state_q, state_d;
    logic                    ready_en_q;
    logic                    cur_q, cur_d;
    logic [CW-1:0]           beat_cnt_q, beat_cnt_d;
    logic [NZW-1:0]          nz_acc_q, nz_acc_d;
    logic [1:0][NZW-1:0]     nz_cnt_q, nz_cnt_d;
    logic [1:0]              full_q, full_d;
    logic                    pend_q, pend_d;
    logic                    pend_bank_q, pend_bank_d;
    logic [BUS_SIZE-1:0]     wr_map_q, wr_map_d;
    logic [BUS_SIZE*8-1:0]   wr_data_q, wr_data_d;
    logic                    wr_valid_q, wr_valid_d;
    logic [CW-1:0]           wr_count_q, wr_count_d;
    logic                    wr_sel_q, wr_sel_d;

    logic [BUS_SIZE-1:0]     map_c;
    logic [BUS_SIZE*8-1:0]   pack_c;
    logic [PW-1:0]           pop_c;
    logic                    accept;
    logic                    beat;
    logic [NZW-1:0]          nz_sum;

    // Nonzero bytes are packed downward; the running pack index doubles as the popcount.
    always_comb begin
        map_c  = '0;
        pack_c = '0;
        pop_c  = '0;
        for (int k = 0; k < BUS_SIZE; k++) begin
            if (in_data_i[k*8 +: 8] != 8'd0) begin
                map_c[k]            = 1'b1;
                pack_c[pop_c*8 +: 8] = in_data_i[k*8 +: 8];
                pop_c               = pop_c + 1'b1;
            end
        end
    end

    // A completed bank is pending for one cycle so the reader never sees full before its last write.
    assign in_ready_o = ready_en_q && (state_q == FILL) && !full_q[cur_q]
                        && !(pend_q && (pend_bank_q == cur_q));
    assign accept     = in_valid_i && in_ready_o;
    assign beat       = accept || (state_q == PAD);

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        beat_cnt_d  = beat_cnt_q;
        nz_acc_d    = nz_acc_q;
        nz_cnt_d    = nz_cnt_q;
        pend_d      = 1'b0;
        pend_bank_d = pend_bank_q;
        wr_map_d    = wr_map_q;
        wr_data_d   = wr_data_q;
        wr_valid_d  = 1'b0;
        wr_count_d  = wr_count_q;
        wr_sel_d    = wr_sel_q;
        nz_sum      = nz_acc_q + (accept ? NZW'(pop_c) : '0);

        full_d = full_q & ~bank_release_i;
        if (pend_q) begin
            full_d[pend_bank_q] = 1'b1;
        end

        if (beat) begin
            wr_valid_d = 1'b1;
            wr_count_d = beat_cnt_q;
            wr_sel_d   = cur_q;
            wr_map_d   = accept ? map_c  : '0;
            wr_data_d  = accept ? pack_c : '0;
            if (beat_cnt_q == CW'(N - 1)) begin
                beat_cnt_d      = '0;
                cur_d           = ~cur_q;
                nz_cnt_d[cur_q] = nz_sum;
                nz_acc_d        = '0;
                pend_d          = 1'b1;
                pend_bank_d     = cur_q;
                state_d         = FILL;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                nz_acc_d   = nz_sum;
                if (accept && in_last_i) begin
                    state_d = PAD;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= FILL;
            ready_en_q  <= 1'b0;
            cur_q       <= 1'b0;
            beat_cnt_q  <= '0;
            nz_acc_q    <= '0;
            nz_cnt_q    <= '0;
            full_q      <= '0;
            pend_q      <= 1'b0;
            pend_bank_q <= 1'b0;
            wr_map_q    <= '0;
            wr_data_q   <= '0;
            wr_valid_q  <= 1'b0;
            wr_count_q  <= '0;
            wr_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_en_q  <= 1'b1;
            cur_q       <= cur_d;
            beat_cnt_q  <= beat_cnt_d;
            nz_acc_q    <= nz_acc_d;
            nz_cnt_q    <= nz_cnt_d;
            full_q      <= full_d;
            pend_q      <= pend_d;
            pend_bank_q <= pend_bank_d;
            wr_map_q    <= wr_map_d;
            wr_data_q   <= wr_data_d;
            wr_valid_q  <= wr_valid_d;
            wr_count_q  <= wr_count_d;
            wr_sel_q    <= wr_sel_d;
        end
    end

    assign wr_sparsemap_o    = wr_map_q;
    assign wr_nonzero_data_o = wr_data_q;
    assign wr_valid_o        = wr_valid_q;
    assign wr_count_o        = wr_count_q;
    assign wr_sel_o          = wr_sel_q;
    assign bank_full_o       = full_q;
    assign chunk_nz_cnt_o    = nz_cnt_q;

endmodule

// File: tb/tb_ifm_sparse_chunk_writer.sv
// tb/tb_ifm_sparse_chunk_writer.sv - self-checking bench for ifm_sparse_chunk_writer
module tb_ifm_sparse_chunk_writer;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [1:0]  rel = '0;
    logic        in_ready;
    logic [7:0]  wr_map;
    logic [63:0] wr_data;
    logic        wr_valid;
    logic [1:0]  wr_count;
    logic        wr_sel;
    logic [1:0]  full;
    logic [11:0] nz;

    int n_chk = 0;
    int n_fail = 0;

    ifm_sparse_chunk_writer #(.BUS_SIZE(8), .MEM_SIZE(32)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_last_i(in_last),
        .wr_sparsemap_o(wr_map), .wr_nonzero_data_o(wr_data), .wr_valid_o(wr_valid),
        .wr_count_o(wr_count), .wr_sel_o(wr_sel),
        .bank_release_i(rel), .bank_full_o(full), .chunk_nz_cnt_o(nz)
    );

    always #5 clk = ~clk;

    // Reference model: transaction-level view of chunks, banks and the expected write beat.
    bit          m_ren, m_pad, m_cur;
    int          m_cnt, m_acc, m_pend;
    logic [1:0]  m_full;
    int          m_nz[2];
    bit          e_valid;
    logic [7:0]  e_map;
    logic [63:0] e_data;
    int          e_cnt;
    bit          e_sel;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void compress(input logic [63:0] d, output logic [7:0] m,
                                     output logic [63:0] p, output int pop);
        byte unsigned q[$];
        m = '0;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            if (d[k*8 +: 8] != 8'd0) begin
                q.push_back(d[k*8 +: 8]);
                m[k] = 1'b1;
            end
        end
        foreach (q[i]) p[i*8 +: 8] = q[i];
        pop = q.size();
    endfunction

    function automatic bit model_ready();
        return m_ren && !m_pad && !m_full[m_cur];
    endfunction

    task automatic model_reset();
        m_ren = 0; m_pad = 0; m_cur = 0; m_cnt = 0; m_acc = 0; m_pend = -1;
        m_full = '0; m_nz[0] = 0; m_nz[1] = 0;
        e_valid = 0; e_map = '0; e_data = '0; e_cnt = 0; e_sel = 0;
    endtask

    task automatic model_edge();
        bit acc;
        int pop;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = in_valid && model_ready();
        m_full = m_full & ~rel;
        if (m_pend >= 0) m_full[m_pend] = 1'b1;
        m_pend = -1;
        e_valid = acc || m_pad;
        if (e_valid) begin
            compress(acc ? in_data : 64'd0, e_map, e_data, pop);
            e_cnt = m_cnt;
            e_sel = m_cur;
            m_acc += pop;
            if (m_cnt == N - 1) begin
                m_nz[m_cur] = m_acc;
                m_acc  = 0;
                m_pend = m_cur;
                m_cur  = !m_cur;
                m_cnt  = 0;
                m_pad  = 0;
            end else begin
                m_cnt++;
                if (acc && in_last) m_pad = 1;
            end
        end
        m_ren = 1;
    endtask

    task automatic model_check();
        chk("in_ready", 64'(in_ready), 64'(model_ready()));
        chk("wr_valid", 64'(wr_valid), 64'(e_valid));
        chk("bank_full", 64'(full), 64'(m_full));
        chk("nz_cnt0", 64'(nz[5:0]), 64'(m_nz[0]));
        chk("nz_cnt1", 64'(nz[11:6]), 64'(m_nz[1]));
        if (e_valid) begin
            chk("wr_sparsemap", 64'(wr_map), 64'(e_map));
            chk("wr_data", wr_data, e_data);
            chk("wr_count", 64'(wr_count), 64'(e_cnt));
            chk("wr_sel", 64'(wr_sel), 64'(e_sel));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    typedef struct {
        logic [63:0] data;
        logic [7:0]  map;
        logic [63:0] packed_nz;
        logic [1:0]  cnt;
        logic        sel;
        logic [1:0]  full_after;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{64'h0900_0000_0700_0500, 8'h8A, 64'h0000_0000_0009_0705, 2'd0, 1'b0, 2'b00};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b0, 2'b00};
        vecs[2] = '{64'h0000_0000_0000_0000, 8'h00, 64'h0000_0000_0000_0000, 2'd2, 1'b0, 2'b00};
        vecs[3] = '{64'h0000_0000_0000_00AB, 8'h01, 64'h0000_0000_0000_00AB, 2'd3, 1'b0, 2'b00};
        vecs[4] = '{64'h1100_0000_0000_0000, 8'h80, 64'h0000_0000_0000_0011, 2'd0, 1'b1, 2'b01};
        vecs[5] = '{64'h0022_0033_0044_0055, 8'h55, 64'h0000_0000_2233_4455, 2'd1, 1'b1, 2'b01};

        model_reset();
        step();
        step();
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_valid", 64'(wr_valid), 64'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // Compression table, spanning a chunk boundary.
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = vecs[i].data;
            step();
            chk("tbl_map", 64'(wr_map), 64'(vecs[i].map));
            chk("tbl_data", wr_data, vecs[i].packed_nz);
            chk("tbl_count", 64'(wr_count), 64'(vecs[i].cnt));
            chk("tbl_sel", 64'(wr_sel), 64'(vecs[i].sel));
            chk("tbl_full", 64'(full), 64'(vecs[i].full_after));
        end
        chk("tbl_nz0", 64'(nz[5:0]), 64'd12);

        // Releasing the partially filled bank 1 must not disturb it.
        in_valid = 1'b0;
        rel = 2'b11;
        step();
        rel = 2'b00;
        chk("rel_nonfull", 64'(full), 64'd0);
        in_valid = 1'b1;
        in_data = '0;
        step();
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("chunk1_full", 64'(full), 64'b10);
        chk("chunk1_nz", 64'(nz[11:6]), 64'd5);
        rel = 2'b10;
        step();
        rel = 2'b00;

        // Two all-0xFF chunks back to back fill both banks.
        in_valid = 1'b1;
        in_data = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("ff_sel", 64'(wr_sel), 64'(i / 4));
            chk("ff_count", 64'(wr_count), 64'(i % 4));
        end
        in_valid = 1'b0;
        step();
        step();
        chk("both_full", 64'(full), 64'b11);
        chk("ff_nz", 64'(nz), {52'd0, 6'd32, 6'd32});
        chk("both_full_ready", 64'(in_ready), 64'd0);
        rel = 2'b01;
        step();
        rel = 2'b00;
        chk("after_rel_full", 64'(full), 64'b10);
        chk("after_rel_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data = 64'h0000_0000_0000_0300;
        step();
        chk("after_rel_sel", 64'(wr_sel), 64'd0);

        // in_last on beat 1 pads beats 2 and 3.
        in_data = 64'h0400_0000_0000_0000;
        in_last = 1'b1;
        step();
        in_last = 1'b0;
        in_data = 64'h1234_5678_9ABC_DEF0;
        step();
        chk("pad_count2", 64'(wr_count), 64'd2);
        chk("pad_map", 64'(wr_map), 64'd0);
        chk("pad_ready", 64'(in_ready), 64'd0);
        in_data = 64'h0F0F_0F0F_0F0F_0F0F;
        step();
        chk("pad_count3", 64'(wr_count), 64'd3);
        chk("pad_valid", 64'(wr_valid), 64'd1);
        rel = 2'b10;
        step();
        rel = 2'b00;
        chk("coincident_full", 64'(full), 64'b01);
        chk("pad_nz0", 64'(nz[5:0]), 64'd2);
        chk("resume_ready", 64'(in_ready), 64'd1);
        step();
        chk("resume_sel", 64'(wr_sel), 64'd1);
        chk("resume_count", 64'(wr_count), 64'd0);

        // Reset in the middle of a chunk.
        step();
        step();
        chk("pre_rst_count", 64'(wr_count), 64'd2);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", 64'(wr_valid), 64'd0);
        chk("mid_rst_full", 64'(full), 64'd0);
        chk("mid_rst_nz", 64'(nz), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data = 64'h0000_0000_0000_0001;
        step();
        chk("post_rst_count", 64'(wr_count), 64'd0);
        chk("post_rst_sel", 64'(wr_sel), 64'd0);

        // Randomised traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_last  = ($urandom_range(0, 9) == 0);
            for (int k = 0; k < 8; k++)
                in_data[k*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
            rel[0] = ($urandom_range(0, 9) == 0);
            rel[1] = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
